register_status_table: RTL

REGISTER_STATUS_TABLE -- requirements
Module: register_status_table

---
 rtl/register_status_table.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/register_status_table.sv
// register_status_table: 32-entry scoreboard mapping architectural registers
// to the row tag of their newest in-flight producer.
// Four zero-latency read ports (Issue a/b, Decode a/b), one allocate port,
// one CDB clear port, a global flush and a registered pending count.
// Optional build macro REGISTER_STATUS_BYPASS_EN: read ports also see a
// same-cycle CDB clear (allocations are never forwarded).

// One table entry: pending bit plus producer row tag.
// Exposes its next-state pending bit so the top can register an exact count.
module rst_entry #(
  parameter int ROW_WIDTH = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 alloc_hit,
  input  logic [ROW_WIDTH-1:0] alloc_row,
  input  logic                 cdb_valid,
  input  logic [ROW_WIDTH-1:0] cdb_row,
  output logic                 pend,
  output logic [ROW_WIDTH-1:0] row,
  output logic                 pend_nxt
);

  logic                 cdb_hit;
  logic [ROW_WIDTH-1:0] row_nxt;

  assign cdb_hit = cdb_valid && pend && (row == cdb_row);

  // Priority: reset (handled in the flop) > flush > allocate > CDB clear.
  // Flush and CDB clear only drop the pending bit; the row tag is kept.
  always_comb begin
    pend_nxt = pend;
    row_nxt  = row;
    if (flush) begin
      pend_nxt = 1'b0;
    end else if (alloc_hit) begin
      pend_nxt = 1'b1;
      row_nxt  = alloc_row;
    end else if (cdb_hit) begin
      pend_nxt = 1'b0;
    end
  end

  // Entry state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend <= 1'b0;
      row  <= '0;
    end else begin
      pend <= pend_nxt;
      row  <= row_nxt;
    end
  end

endmodule

module register_status_table #(
  parameter int ROW_WIDTH = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [4:0]           iss_reg_a,
  input  logic [4:0]           iss_reg_b,
  output logic                 iss_ass_pending_a,
  output logic                 iss_ass_pending_b,
  output logic [ROW_WIDTH-1:0] iss_ass_row_a,
  output logic [ROW_WIDTH-1:0] iss_ass_row_b,
  input  logic [4:0]           id_reg_a,
  input  logic [4:0]           id_reg_b,
  output logic                 id_ass_pending_a,
  output logic                 id_ass_pending_b,
  output logic [ROW_WIDTH-1:0] id_ass_row_a,
  output logic [ROW_WIDTH-1:0] id_ass_row_b,
  input  logic                 alloc_en,
  input  logic [4:0]           alloc_reg,
  input  logic [ROW_WIDTH-1:0] alloc_row,
  input  logic                 cdb_valid,
  input  logic [ROW_WIDTH-1:0] cdb_row,
  input  logic                 flush,
  output logic [5:0]           pending_count
);

  localparam int NUM_ENT = 32;
  localparam int NUM_RD  = 4;

  logic [NUM_ENT-1:0]                pend;
  logic [NUM_ENT-1:0]                pend_nxt;
  logic [NUM_ENT-1:0][ROW_WIDTH-1:0] row;
  logic [5:0]                        cnt_nxt;

  // ---------------------------------------------------------------------
  // Table entries. Register 0 is hardwired idle: never pending, row 0, so
  // allocations to it fall away and every read of it returns zeros.
  // ---------------------------------------------------------------------
  assign pend[0]     = 1'b0;
  assign pend_nxt[0] = 1'b0;
  assign row[0]      = '0;

  for (genvar i = 1; i < NUM_ENT; i++) begin : g_ent
    logic alloc_hit;
    assign alloc_hit = alloc_en && (alloc_reg == 5'(i));

    rst_entry #(.ROW_WIDTH(ROW_WIDTH)) u_ent (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .alloc_hit (alloc_hit),
      .alloc_row (alloc_row),
      .cdb_valid (cdb_valid),
      .cdb_row   (cdb_row),
      .pend      (pend[i]),
      .row       (row[i]),
      .pend_nxt  (pend_nxt[i])
    );
  end

  // ---------------------------------------------------------------------
  // Pending count: population count of the next-state pending vector, so
  // simultaneous allocate / clear / WAW re-allocation are all accounted
  // for exactly, with no incremental bookkeeping to drift.
  // ---------------------------------------------------------------------

  // Population count of next-cycle pending bits.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_ENT; i++)
      cnt_nxt = cnt_nxt + {5'b0, pend_nxt[i]};
  end

  // Registered count; reset forces zero.
  always_ff @(posedge clock) begin
    if (reset) pending_count <= '0;
    else       pending_count <= cnt_nxt;
  end

  // ---------------------------------------------------------------------
  // Read ports: index 0/1 = Issue a/b, 2/3 = Decode a/b.
  // ---------------------------------------------------------------------
  logic [NUM_RD-1:0][4:0]           rd_reg;
  logic [NUM_RD-1:0]                rd_pend;
  logic [NUM_RD-1:0][ROW_WIDTH-1:0] rd_row;

  assign rd_reg = {id_reg_b, id_reg_a, iss_reg_b, iss_reg_a};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic                 ent_pend;
    logic [ROW_WIDTH-1:0] ent_row;

    assign ent_pend = pend[rd_reg[p]];
    assign ent_row  = row[rd_reg[p]];

`ifdef REGISTER_STATUS_BYPASS_EN
    // A CDB broadcast for this entry's tag is visible in the same cycle.
    assign rd_pend[p] = ent_pend && !(cdb_valid && (cdb_row == ent_row));
`else
    // Registered view only: a CDB clear shows up after the next edge.
    assign rd_pend[p] = ent_pend;
`endif
    assign rd_row[p] = ent_row;
  end

  assign iss_ass_pending_a = rd_pend[0];
  assign iss_ass_pending_b = rd_pend[1];
  assign id_ass_pending_a  = rd_pend[2];
  assign id_ass_pending_b  = rd_pend[3];
  assign iss_ass_row_a     = rd_row[0];
  assign iss_ass_row_b     = rd_row[1];
  assign id_ass_row_a      = rd_row[2];
  assign id_ass_row_b      = rd_row[3];

endmodule
